// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry {pc, inst} buffer, redirect and halt
// Optional FETCH_MISALIGN_TRAP_EN: sticky fetch_error on misaligned redirect, blocks further fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        fetch_error
);

    logic [31:0] r_pc_f;
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_tail;
    logic [31:0] r_buf_pc   [2];
    logic [31:0] r_buf_inst [2];

    logic        w_pop;
    logic        w_push;
    logic        w_fetch_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fetch_error;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_error <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_fetch_error <= 1'b1;
        end
    end

    assign fetch_error   = r_fetch_error;
    assign w_fetch_block = r_fetch_error;
`else
    assign fetch_error   = 1'b0;
    assign w_fetch_block = 1'b0;
`endif

    assign imem_addr = r_pc_f[31:2];

    assign out_valid = (r_count != 2'd0) && !redirect_valid;
    assign out_pc    = r_buf_pc[r_head];
    assign out_inst  = r_buf_inst[r_head];
    assign out_pc4   = out_pc + 32'd4;

    // A full buffer that is popping this cycle may still accept a new word.
    assign w_pop  = out_valid && out_ready;
    assign w_push = !redirect_valid && !halt && !w_fetch_block &&
                    ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc_f        <= RESET_PC;
            r_count       <= 2'd0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_buf_pc[0]   <= 32'd0;
            r_buf_pc[1]   <= 32'd0;
            r_buf_inst[0] <= 32'd0;
            r_buf_inst[1] <= 32'd0;
        end else if (redirect_valid) begin
            r_pc_f  <= redirect_pc & 32'hFFFF_FFFC;
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_tail]   <= r_pc_f;
                r_buf_inst[r_tail] <= imem_data;
                r_tail             <= ~r_tail;
                r_pc_f             <= r_pc_f + 32'd4;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a queue-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic [29:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        fetch_error;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock          (clk),
        .reset          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4),
        .fetch_error    (fetch_error)
    );

    function automatic logic [31:0] imem_word(input logic [29:0] a);
        return {a[14:0], a[29:13]} ^ 32'hC0DE_1234;
    endfunction

    assign imem_data = imem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [29:0] addr;
        logic        err;
        logic        zero;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("out_valid", {31'd0, out_valid}, {31'd0, mon_e.valid});
            chk("imem_addr", {2'd0, imem_addr}, {2'd0, mon_e.addr});
            chk("fetch_error", {31'd0, fetch_error}, {31'd0, mon_e.err});
            if (mon_e.valid) begin
                chk("out_pc", out_pc, mon_e.pc);
                chk("out_inst", out_inst, mon_e.inst);
                chk("out_pc4", out_pc4, mon_e.pc + 32'd4);
            end
            if (mon_e.zero) begin
                chk("reset_out_pc", out_pc, 32'd0);
                chk("reset_out_inst", out_inst, 32'd0);
            end
        end
    end

    // Drive one cycle's inputs, record what the model says the outputs must be, then advance the model.
    task automatic step(input logic rn, input logic r, input logic [31:0] rp,
                        input logic h, input logic rdy);
        exp_t e;
        logic pop;
        logic push;
        @(posedge clk);
        #1;
        rst_n          = rn;
        redirect_valid = r;
        redirect_pc    = rp;
        halt           = h;
        out_ready      = rdy;
        if (!rn) begin
            m_q.delete();
            m_pc  = RESET_PC;
            m_err = 1'b0;
            e.valid = 1'b0; e.pc = 32'd0; e.inst = 32'd0;
            e.addr  = RESET_PC[31:2]; e.err = 1'b0; e.zero = 1'b1;
            sb.push_back(e);
        end else begin
            e.valid = (m_q.size() != 0) && !r;
            e.pc    = e.valid ? m_q[0] : 32'd0;
            e.inst  = imem_word(e.pc[31:2]);
            e.addr  = m_pc[31:2];
            e.err   = m_err;
            e.zero  = 1'b0;
            sb.push_back(e);
            pop  = e.valid && rdy;
            push = !r && !h && !m_err && ((m_q.size() < 2) || pop);
            if (r) begin
                m_q.delete();
                m_pc = {rp[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
                if (rp[1:0] != 2'b00) m_err = 1'b1;
`endif
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic run(input int n, input logic h, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, h, rdy);
    endtask

    initial begin
        logic [31:0] rp;
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        run(6, 1'b0, 1'b1);
        // mid-operation reset, then stall to saturate the buffer
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);
        run(6, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0);
        run(6, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        run(5, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h0040_0200, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1);
        run(4, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2))
                                               : (32'h0040_0000 + ($urandom_range(0, 255) << 2));
`ifndef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
`endif
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 15) == 0), rp,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        run(3, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h0040_0102, 1'b0, 1'b1);
        run(8, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Holds the program counter and drives the word address to memory.
- Captures the returned 32-bit instruction together with its PC into a 2-entry buffer.
- Hands instructions to decode over a valid/ready handshake; supports branch/jump redirect with flush, and a halt input.

Parameters:
- RESET_PC, 32'h0040_0000, byte address loaded into PC on reset; bits [1:0] must be 0.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  30  word address to instruction memory; equals pc_f[31:2].
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  load redirect_pc into PC; flush buffer.
- redirect_pc  input  32  redirect target byte address.
- halt  input  1  suppress new fetches while high.
- out_valid  output  1  buffer head holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_inst  output  32  head instruction.
- out_pc  output  32  head instruction byte address.
- out_pc4  output  32  out_pc + 4, modulo 2^32.
- fetch_error  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
Fetch PC
- pc_f is a 32-bit register; imem_addr = pc_f[31:2], combinational from pc_f.
- Reset values: pc_f = RESET_PC, count = 0, out_valid = 0, out_inst/out_pc = 0, fetch_error = 0.

Buffer
- Two-entry circular FIFO of {pc, inst}; 2-bit count (0..2), 1-bit head and tail pointers.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & ~halt & (count < 2 | pop).
  - Full buffer with simultaneous pop still pushes, giving sustained 1 instr/cycle.
- On push:
  - write {pc_f, imem_data} at tail; advance tail.
  - pc_f <= pc_f + 4; wraps 32'hFFFF_FFFC to 0.
- On pop: advance head.
- count update: count + push − pop.
- Outputs from head entry: out_valid = (count != 0) & ~redirect_valid.
- Latency: an instruction pushed in cycle N appears on out_* in cycle N+1.

Redirect
- Highest priority. In the redirect_valid cycle:
  - out_valid forced 0; no pop, no push.
  - next state: count = 0, head = tail = 0, pc_f = {redirect_pc[31:2], 2'b00}.
- First redirected instruction is pushed the cycle after redirect and presented the cycle after that.
- Redirect while halt is high: PC and flush still take effect.

Halt
- Stops push only.
- Buffered entries still drain via pop.
- pc_f holds its value.

Empty/full
- count == 0: out_valid = 0; out_ready ignored.
- count == 2 and no pop: no push; pc_f holds.

Reset
- Asynchronous assertion at any point, including mid-operation, clears all state to reset values immediately.
- Deassertion is sampled at the next clock edge.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect_valid with redirect_pc[1:0] != 0 sets fetch_error (sticky until reset).
  - While fetch_error = 1, push is blocked; drain continues.
  - The flush and pc_f load still occur, with bits [1:0] forced to 0.
- Undefined:
  - fetch_error tied 0.
  - redirect_pc[1:0] silently ignored.

Test Plan:
- Reset release, out_ready = 1, imem returns addr-dependent words -> out_pc sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles starting the 2nd cycle after reset; out_pc4 = out_pc + 4.
- out_ready = 0 for 5 cycles -> count saturates at 2; imem_addr holds 0x00100002; on out_ready = 1, out_pc resumes 0x00400000, 0x00400004, 0x00400008 with no gaps or duplicates.
- redirect_valid with redirect_pc = 0x00400100 while buffer full -> out_valid = 0 that cycle and the next; then out_pc = 0x00400100; old entries never appear.
- halt = 1 for 3 cycles with out_ready = 1 -> buffer drains to out_valid = 0; imem_addr constant; fetch resumes at the same PC after halt drops.
- Redirect to 0xFFFFFFFC -> out_pc 0xFFFFFFFC then 0x00000000; out_pc4 for the first = 0x00000000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc = 0x00400102 -> fetch_error = 1 next cycle and stays; no further out_valid.
  - Without the macro, same stimulus -> fetch_error = 0 and fetch proceeds from 0x00400100.
